// File: rtl/pusch_descrambler_pkg.sv
// Shared definitions for the PUSCH descrambler: FSM encoding, Gold x1 seed,
// default warm-up length and LLR saturation helpers.
package pusch_descrambler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } dsc_state_e;

    localparam logic [30:0] X1_INIT    = 31'h0000_0001;
    localparam int          NC_DEFAULT = 1600;

    // Two's complement extremes for a w-bit LLR.
    function automatic int llr_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int llr_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/pusch_gold_gen.sv
// Length-31 Gold sequence generator (x1/x2 LFSR pair); c is the current chip,
// load reseeds both registers, step advances them by one position.
module pusch_gold_gen
    import pusch_descrambler_pkg::*;
(
    input  logic        CLK_DSC,
    input  logic        RST_DSC,
    input  logic        load,
    input  logic [30:0] c_init,
    input  logic        step,
    output logic        c
);

    logic [30:0] x1_reg, x1_next;
    logic [30:0] x2_reg, x2_next;

    // load wins over step so a fresh block always starts from the seed.
    always_comb begin
        x1_next = x1_reg;
        x2_next = x2_reg;
        if (load) begin
            x1_next = X1_INIT;
            x2_next = c_init;
        end else if (step) begin
            x1_next = {x1_reg[3] ^ x1_reg[0], x1_reg[30:1]};
            x2_next = {x2_reg[3] ^ x2_reg[2] ^ x2_reg[1] ^ x2_reg[0], x2_reg[30:1]};
        end
    end

    always_ff @(posedge CLK_DSC or negedge RST_DSC) begin
        if (!RST_DSC) begin
            x1_reg <= '0;
            x2_reg <= '0;
        end else begin
            x1_reg <= x1_next;
            x2_reg <= x2_next;
        end
    end

    assign c = x1_reg[0] ^ x2_reg[0];

endmodule

// File: rtl/pusch_descrambler.sv
// PUSCH soft-bit descrambler: flips the sign of each accepted LLR where the
// Gold chip is 1 (saturating), with valid/ready on both sides.
module pusch_descrambler
    import pusch_descrambler_pkg::*;
#(
    parameter int LLR_W = 8,
    parameter int LEN_W = 16,
    parameter int NC    = NC_DEFAULT
)
(
    input  logic             CLK_DSC,
    input  logic             RST_DSC,
    input  logic             DSC_START,
    input  logic [30:0]      DSC_CINIT,
    input  logic [LEN_W-1:0] DSC_LEN,
    input  logic [LLR_W-1:0] DSC_LLR_IN,
    input  logic             DSC_VALID_IN,
    output logic             DSC_READY_OUT,
    output logic [LLR_W-1:0] DSC_LLR_OUT,
    output logic             DSC_VALID_OUT,
    input  logic             DSC_READY_IN,
    output logic             DSC_BUSY_OUT,
    output logic             DSC_DONE
);

    localparam int               WARM_W  = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [LLR_W-1:0] LLR_MAX = LLR_W'(llr_max(LLR_W));
    localparam logic [LLR_W-1:0] LLR_MIN = LLR_W'(llr_min(LLR_W));

    dsc_state_e       state_reg, state_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] bit_cnt_reg;
    logic [WARM_W-1:0] warm_cnt_reg;
    logic [LLR_W-1:0] llr_out_reg;
    logic             valid_out_reg;
    logic             done_reg;

    logic             gold_c;
    logic             gold_step;
    logic             start_ok;
    logic             accept;
    logic             out_hs;
    logic             ready_out;
    logic             last_bit;
    logic             warm_last;
    logic [LLR_W-1:0] llr_desc;

    assign start_ok  = (state_reg == ST_IDLE) && DSC_START;
    assign ready_out = (state_reg == ST_RUN) && (!valid_out_reg || DSC_READY_IN);
    assign accept    = ready_out && DSC_VALID_IN;
    assign out_hs    = valid_out_reg && DSC_READY_IN;
    assign last_bit  = (bit_cnt_reg == len_reg - LEN_W'(1));
    assign warm_last = (warm_cnt_reg == WARM_W'(NC - 1));
    assign gold_step = (state_reg == ST_WARM) || accept;

    pusch_gold_gen u_gold (
        .CLK_DSC (CLK_DSC),
        .RST_DSC (RST_DSC),
        .load    (start_ok),
        .c_init  (DSC_CINIT),
        .step    (gold_step),
        .c       (gold_c)
    );

    // Negating the most negative code would wrap, so it clamps to the maximum.
    always_comb begin
        llr_desc = DSC_LLR_IN;
        if (gold_c) begin
            llr_desc = (DSC_LLR_IN == LLR_MIN) ? LLR_MAX : (~DSC_LLR_IN + LLR_W'(1));
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (DSC_START) begin
                    if (DSC_LEN == '0) begin
                        state_next = ST_IDLE;
                    end else if (NC == 0) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_WARM;
                    end
                end
            end
            ST_WARM: begin
                if (warm_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_bit) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_DSC or negedge RST_DSC) begin
        if (!RST_DSC) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            bit_cnt_reg   <= '0;
            warm_cnt_reg  <= '0;
            llr_out_reg   <= '0;
            valid_out_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                len_reg      <= DSC_LEN;
                bit_cnt_reg  <= '0;
                warm_cnt_reg <= '0;
            end else begin
                if (state_reg == ST_WARM) begin
                    warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
                end
                if (accept) begin
                    bit_cnt_reg <= bit_cnt_reg + LEN_W'(1);
                end
            end
            // A new accept overrides a simultaneous handoff, keeping VALID high.
            if (accept) begin
                llr_out_reg   <= llr_desc;
                valid_out_reg <= 1'b1;
            end else if (out_hs) begin
                valid_out_reg <= 1'b0;
            end
            done_reg <= (start_ok && (DSC_LEN == '0)) || ((state_reg == ST_DRAIN) && out_hs);
        end
    end

    assign DSC_READY_OUT = ready_out;
    assign DSC_LLR_OUT   = llr_out_reg;
    assign DSC_VALID_OUT = valid_out_reg;
    assign DSC_BUSY_OUT  = (state_reg != ST_IDLE);
    assign DSC_DONE      = done_reg;

endmodule

// File: tb/tb_pusch_descrambler.sv
// Directed bench for pusch_descrambler: table-driven short blocks on an NC=0
// instance plus a full-warm-up block on an NC=1600 instance.
module tb_pusch_descrambler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // NC = 0 instance
    logic        s_start, s_valid_in, s_ready_in, s_ready_out, s_valid_out, s_busy, s_done;
    logic [30:0] s_cinit;
    logic [15:0] s_len;
    logic [7:0]  s_llr_in, s_llr_out;

    // NC = 1600 instance
    logic        l_start, l_valid_in, l_ready_in, l_ready_out, l_valid_out, l_busy, l_done;
    logic [30:0] l_cinit;
    logic [15:0] l_len;
    logic [7:0]  l_llr_in, l_llr_out;

    pusch_descrambler #(.LLR_W(8), .LEN_W(16), .NC(0)) u_dut_nc0 (
        .CLK_DSC(clk), .RST_DSC(rst_n), .DSC_START(s_start), .DSC_CINIT(s_cinit),
        .DSC_LEN(s_len), .DSC_LLR_IN(s_llr_in), .DSC_VALID_IN(s_valid_in),
        .DSC_READY_OUT(s_ready_out), .DSC_LLR_OUT(s_llr_out), .DSC_VALID_OUT(s_valid_out),
        .DSC_READY_IN(s_ready_in), .DSC_BUSY_OUT(s_busy), .DSC_DONE(s_done)
    );

    pusch_descrambler #(.LLR_W(8), .LEN_W(16), .NC(1600)) u_dut_nc1600 (
        .CLK_DSC(clk), .RST_DSC(rst_n), .DSC_START(l_start), .DSC_CINIT(l_cinit),
        .DSC_LEN(l_len), .DSC_LLR_IN(l_llr_in), .DSC_VALID_IN(l_valid_in),
        .DSC_READY_OUT(l_ready_out), .DSC_LLR_OUT(l_llr_out), .DSC_VALID_OUT(l_valid_out),
        .DSC_READY_IN(l_ready_in), .DSC_BUSY_OUT(l_busy), .DSC_DONE(l_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    int  cyc = 0;
    int  s_out_q[$];
    int  l_out_q[$];
    int  s_done_cnt = 0, s_done_cyc = 0, s_last_hs_cyc = 0;
    int  l_done_cnt = 0;
    int  stall_viol = 0;
    bit  prev_stall = 0;
    logic [7:0] prev_val = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!s_valid_out || s_llr_out != prev_val)) stall_viol++;
            prev_stall = s_valid_out && !s_ready_in;
            prev_val   = s_llr_out;
            if (s_valid_out && s_ready_in) begin
                s_out_q.push_back(int'($signed(s_llr_out)));
                s_last_hs_cyc = cyc;
            end
            if (s_done) begin
                s_done_cnt++;
                s_done_cyc = cyc;
            end
            if (l_valid_out && l_ready_in) l_out_q.push_back(int'($signed(l_llr_out)));
            if (l_done) l_done_cnt++;
        end
    end

    // ---------------- downstream ready driver ----------------
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
    initial begin
        s_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) s_ready_in = 1'($urandom_range(0, 1));
            else s_ready_in = (rdy_mode == 0);
        end
    end

    // ---------------- reference 38.211 model ----------------
    bit x1s[0:4095];
    bit x2s[0:4095];
    bit cseq[0:4095];

    function automatic void build_c(input logic [30:0] cinit, input int nc, input int len);
        for (int n = 0; n < 31; n++) begin
            x1s[n] = (n == 0);
            x2s[n] = cinit[n];
        end
        for (int n = 0; n < nc + len; n++) begin
            x1s[n + 31] = x1s[n + 3] ^ x1s[n];
            x2s[n + 31] = x2s[n + 3] ^ x2s[n + 2] ^ x2s[n + 1] ^ x2s[n];
        end
        for (int n = 0; n < len; n++) cseq[n] = x1s[n + nc] ^ x2s[n + nc];
    endfunction

    function automatic int desc_model(input int x, input bit c);
        int v;
        if (!c) return x;
        v = -x;
        if (v > 127) v = 127;
        return v;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        int cinit;
        int len;
        int llr[4];
        int exp[4];
    } vec_t;
    vec_t tbl[6];

    task automatic set_vec(input int k, input int cinit, input int len,
                           input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        tbl[k].cinit = cinit;
        tbl[k].len = len;
        tbl[k].llr[0] = a0; tbl[k].llr[1] = a1; tbl[k].llr[2] = a2; tbl[k].llr[3] = a3;
        tbl[k].exp[0] = b0; tbl[k].exp[1] = b1; tbl[k].exp[2] = b2; tbl[k].exp[3] = b3;
    endtask

    int stim_q[$];

    // Runs one block on the NC=0 instance using stim_q; optionally gaps the input
    // and pokes DSC_START while the block is running.
    task automatic run_short(input logic [30:0] cinit, input int len, input bit gap,
                             input bit poke, output int base_out, output int done_before);
        bit hs;
        int n;
        base_out = s_out_q.size();
        done_before = s_done_cnt;
        s_cinit = cinit;
        s_len = 16'(len);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (gap && $urandom_range(0, 2) == 0) begin
                s_valid_in = 1'b0;
                @(posedge clk); #1;
            end
            if (poke && i == 2) begin
                s_start = 1'b1;
                s_cinit = 31'd2;
                s_len = 16'd1;
            end
            s_valid_in = 1'b1;
            s_llr_in = 8'(stim_q[i]);
            n = 0;
            do begin
                @(negedge clk);
                hs = s_ready_out;
                @(posedge clk); #1;
                n++;
            end while (!hs && n < 500);
            s_start = 1'b0;
            if (!hs) check("accept_timeout", 0, 1);
        end
        s_valid_in = 1'b0;
        n = 0;
        while (s_done_cnt == done_before && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    int base, dbefore, exp_v, cnt, busy_low, loops, lbase, ldone0;
    bit hs;
    logic [30:0] rc;

    initial begin
        rst_n = 1'b0;
        s_start = 0; s_cinit = '0; s_len = '0; s_llr_in = '0; s_valid_in = 0;
        l_start = 0; l_cinit = '0; l_len = '0; l_llr_in = '0; l_valid_in = 0; l_ready_in = 1;
        #2;
        check("rst_valid_out", int'(s_valid_out), 0);
        check("rst_ready_out", int'(s_ready_out), 0);
        check("rst_llr_out", int'(s_llr_out), 0);
        check("rst_busy", int'(s_busy), 0);
        check("rst_done", int'(s_done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_vec(0, 0, 4,    5,  5, 5, 5,    -5,  5, 5, 5);
        set_vec(1, 2, 3,    3, -7, 1, 0,    -3,  7, 1, 0);
        set_vec(2, 0, 1, -128,  0, 0, 0,   127,  0, 0, 0);
        set_vec(3, 0, 1,  127,  0, 0, 0,  -127,  0, 0, 0);
        set_vec(4, 1, 2, -128, -1, 0, 0,  -128, -1, 0, 0);
        set_vec(5, 3, 2,   10, -128, 0, 0,  10, 127, 0, 0);

        for (int k = 0; k < 6; k++) begin
            stim_q.delete();
            for (int i = 0; i < tbl[k].len; i++) stim_q.push_back(tbl[k].llr[i]);
            run_short(31'(tbl[k].cinit), tbl[k].len, 1'b0, 1'b0, base, dbefore);
            check($sformatf("v%0d_count", k), s_out_q.size() - base, tbl[k].len);
            for (int i = 0; i < tbl[k].len; i++)
                if (base + i < s_out_q.size())
                    check($sformatf("v%0d_out%0d", k, i), s_out_q[base + i], tbl[k].exp[i]);
            check($sformatf("v%0d_done_count", k), s_done_cnt - dbefore, 1);
            check($sformatf("v%0d_done_latency", k), s_done_cyc - s_last_hs_cyc, 1);
            $display("block %0d cinit=%0d len=%0d outputs=%0d", k, tbl[k].cinit, tbl[k].len,
                     s_out_q.size() - base);
        end

        // LEN = 0: back to IDLE at once, DONE the following cycle
        s_cinit = '0; s_len = '0; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(negedge clk);
        check("len0_done", int'(s_done), 1);
        check("len0_busy", int'(s_busy), 0);
        check("len0_ready", int'(s_ready_out), 0);
        @(negedge clk);
        check("len0_done_drop", int'(s_done), 0);
        @(posedge clk); #1;
        $display("block len0 done observed");

        // START during RUN is ignored
        stim_q.delete();
        repeat (4) stim_q.push_back(5);
        run_short(31'd0, 4, 1'b0, 1'b1, base, dbefore);
        check("poke_count", s_out_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < s_out_q.size())
                check($sformatf("poke_out%0d", i), s_out_q[base + i], (i == 0) ? -5 : 5);
        check("poke_done_count", s_done_cnt - dbefore, 1);
        $display("block start-during-run outputs=%0d", s_out_q.size() - base);

        // Backpressure and gapped input
        rc = 31'h1234_5678;
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(int'($urandom_range(0, 255)) - 128);
        stim_q[7] = -128;
        build_c(rc, 0, 20);
        rdy_mode = 1;
        run_short(rc, 20, 1'b1, 1'b0, base, dbefore);
        rdy_mode = 0;
        @(posedge clk); #1;
        check("bp_count", s_out_q.size() - base, 20);
        for (int i = 0; i < 20; i++)
            if (base + i < s_out_q.size()) begin
                exp_v = desc_model(stim_q[i], cseq[i]);
                check($sformatf("bp_out%0d", i), s_out_q[base + i], exp_v);
            end
        check("bp_done_count", s_done_cnt - dbefore, 1);
        check("bp_stall_hold_violations", stall_viol, 0);
        $display("block backpressure outputs=%0d", s_out_q.size() - base);

        // Full NC=1600 warm-up, bit-exact against the reference model
        rc = 31'($urandom());
        stim_q.delete();
        for (int i = 0; i < 1000; i++) stim_q.push_back(int'($urandom_range(0, 255)) - 128);
        stim_q[5] = -128;
        build_c(rc, 1600, 1000);
        lbase = l_out_q.size();
        ldone0 = l_done_cnt;
        l_cinit = rc; l_len = 16'd1000; l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        cnt = 0; busy_low = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (l_ready_out) break;
            if (!l_busy) busy_low++;
            cnt++;
        end
        check("warm_ready_low_cycles", cnt, 1600);
        check("warm_busy_low_cycles", busy_low, 0);
        @(posedge clk); #1;
        loops = 0;
        for (int i = 0; i < 1000; i++) begin
            l_valid_in = 1'b1;
            l_llr_in = 8'(stim_q[i]);
            hs = 0;
            for (int n = 0; n < 50 && !hs; n++) begin
                @(negedge clk);
                hs = l_ready_out;
                @(posedge clk); #1;
                loops++;
            end
        end
        l_valid_in = 1'b0;
        for (int n = 0; n < 50 && l_done_cnt == ldone0; n++) begin
            @(posedge clk); #1;
        end
        check("long_throughput_cycles", loops, 1000);
        check("long_count", l_out_q.size() - lbase, 1000);
        for (int i = 0; i < 1000; i++)
            if (lbase + i < l_out_q.size())
                check($sformatf("long_out%0d", i), l_out_q[lbase + i], desc_model(stim_q[i], cseq[i]));
        check("long_done_count", l_done_cnt - ldone0, 1);
        $display("block nc1600 cinit=%0h outputs=%0d", rc, l_out_q.size() - lbase);

        // Reset mid-RUN with a stalled output register
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        dbefore = s_done_cnt;
        s_cinit = '0; s_len = 16'd8; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_valid_in = 1'b1; s_llr_in = 8'd5;
        @(posedge clk); #1;
        s_valid_in = 1'b0;
        @(negedge clk);
        check("prerst_valid", int'(s_valid_out), 1);
        check("prerst_llr", int'($signed(s_llr_out)), -5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", int'(s_valid_out), 0);
        check("midrst_llr_out", int'(s_llr_out), 0);
        check("midrst_ready_out", int'(s_ready_out), 0);
        check("midrst_busy", int'(s_busy), 0);
        check("midrst_done", int'(s_done), 0);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_done", s_done_cnt - dbefore, 0);
        $display("block reset-mid-run aborted");

        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(tbl[1].llr[i]);
        run_short(31'd2, 3, 1'b0, 1'b0, base, dbefore);
        check("post_rst_count", s_out_q.size() - base, 3);
        for (int i = 0; i < 3; i++)
            if (base + i < s_out_q.size())
                check($sformatf("post_rst_out%0d", i), s_out_q[base + i], tbl[1].exp[i]);
        check("post_rst_done_count", s_done_cnt - dbefore, 1);
        $display("block post-reset outputs=%0d", s_out_q.size() - base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pusch_descrambler.md
Name: pusch_descrambler

Overview:
Receive-side counterpart of the PUSCH bit scrambler: removes the 3GPP TS 38.211 Gold-sequence scrambling from soft-bit LLRs before rate recovery and deinterleaving. It contains its own Gold generator, which is loaded from c_init and advanced by NC before use. Each accepted LLR has its sign flipped when c(n)=1, with saturation. It sits between the soft demapper (upstream) and the deinterleaver (downstream), using valid/ready handshakes on both sides.

Parameters:
LLR_W, 8, LLR width, two's complement signed
LEN_W, 16, width of block-length field
NC, 1600, Gold sequence advance before first output bit

Ports:
CLK_DSC  input  1  clock
RST_DSC  input  1  asynchronous active-low reset
DSC_START  input  1  one-cycle start pulse; sampled only in IDLE
DSC_CINIT  input  31  c_init, latched on accepted start
DSC_LEN  input  LEN_W  number of LLRs in block (E), latched on accepted start
DSC_LLR_IN  input  LLR_W  soft bit from demapper
DSC_VALID_IN  input  1  DSC_LLR_IN valid
DSC_READY_OUT  output  1  block can accept an LLR this cycle
DSC_LLR_OUT  output  LLR_W  descrambled LLR
DSC_VALID_OUT  output  1  DSC_LLR_OUT valid
DSC_READY_IN  input  1  downstream ready
DSC_BUSY_OUT  output  1  high in any state other than IDLE
DSC_DONE  output  1  one-cycle pulse when the last LLR of the block is handed off

Behaviour:
- Reset: all outputs 0; state IDLE; x1, x2, counters cleared. Reset mid-block aborts immediately, with no DONE pulse.
- Gold sequences:
  - x1 init: bit0=1, bits 30..1 = 0. x2 init = DSC_CINIT.
  - Per step: x1 <= {x1[3]^x1[0], x1[30:1]}; x2 <= {x2[3]^x2[2]^x2[1]^x2[0], x2[30:1]}.
  - c = x1[0]^x2[0].
- FSM IDLE -> WARM -> RUN -> DRAIN -> IDLE:
  - IDLE: on DSC_START, latch CINIT/LEN and load x1/x2.
    - LEN=0: go directly back to IDLE and pulse DSC_DONE the next cycle.
    - Else NC=0: go to RUN.
    - Else: go to WARM.
  - WARM: one Gold step per cycle for exactly NC cycles (counter 0..NC-1), then RUN. DSC_READY_OUT=0 throughout.
  - RUN: DSC_READY_OUT = !DSC_VALID_OUT || DSC_READY_IN.
    - Accept when DSC_VALID_IN && DSC_READY_OUT. The Gold step and bit counter advance only on accept.
    - On accepting bit index LEN-1, go to DRAIN.
  - DRAIN: DSC_READY_OUT=0. When DSC_VALID_OUT && DSC_READY_IN, pulse DSC_DONE that cycle and go to IDLE.
- DSC_START is ignored outside IDLE.
- Datapath: single output register, latency 1 cycle from accept to DSC_VALID_OUT.
  - c=0: output = input.
  - c=1: output = -input. The single overflow case -(−2^(LLR_W−1)) saturates to +(2^(LLR_W−1)−1).
- Output stall: DSC_LLR_OUT and DSC_VALID_OUT hold while DSC_VALID_OUT && !DSC_READY_IN.
- Output update:
  - Simultaneous output handshake and new accept: register updates to the new value and VALID stays 1.
  - Output handshake with no new accept: VALID drops to 0.
- Full throughput: 1 LLR/cycle when upstream and downstream are both always ready.

Decomposition:
- Shared package: state encoding (IDLE/WARM/RUN/DRAIN), x1 init constant, default NC, LLR saturation limits.
- One natural sub-module, pusch_gold_gen:
  - Inputs: load, c_init, step.
  - Output: c.
  - Holds x1/x2 and the tap logic; reusable by the transmit-side PR generator.

Test Plan:
- NC=0, CINIT=0, LEN=4, LLRs +5,+5,+5,+5, always ready -> outputs −5,+5,+5,+5 (c=1,0,0,0); DONE one cycle after the 4th output handshake completes.
- NC=0, CINIT=2, LEN=3, LLRs +3,−7,+1 -> c=1,1,0 -> outputs −3,+7,+1.
- LLR_W=8, NC=0, CINIT=0, LEN=1, LLR −128 -> output +127 (saturation).
- Default NC=1600, random CINIT, LEN=1000, random LLRs -> no READY_OUT during 1600 WARM cycles; output bit-exact against a software 38.211 model.
- Backpressure: DSC_READY_IN toggled randomly and DSC_VALID_IN gapped -> no loss or duplication, output held stable while stalled, order preserved, exactly one DONE.
- DSC_START pulsed during RUN is ignored; reset asserted mid-RUN -> all outputs 0 in the same cycle, no DONE; a new START afterwards runs a clean block.
